// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register load controller and its arbiter.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
package shift_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   // Bit-counter width: enough to count 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter owning the last-served pointer.
// Latency: grants are combinational from the valids; the pointer updates on the grant edge.
// Backpressure: grants only while enable is high; an un-granted requester simply waits.
module rr_arbiter_2 (
   input  logic CLOCK,
   input  logic RESET_N,
   input  logic VALID_A,
   input  logic VALID_B,
   input  logic enable,
   output logic GRANT_A,
   output logic GRANT_B
);

   // prio_b = 1 means B was not served last and wins a tie; reset favours A.
   logic prio_b;

   // Grant the lone valid requester, or on a tie the one favoured by the pointer.
   always_comb begin
      GRANT_A = enable & VALID_A & (~VALID_B | ~prio_b);
      GRANT_B = enable & VALID_B & (~VALID_A |  prio_b);
   end

   // A grant is always taken (it implies valid), so flip priority to the other side.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         prio_b <= 1'b0;
      end else if (GRANT_A) begin
         prio_b <= 1'b1;
      end else if (GRANT_B) begin
         prio_b <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_load_controller.sv
// Serialises arbitrated parallel words MSB-first into a left-shift register and verifies Q.
// Latency: SHIFT_LEFT high REG_SIZE cycles after accept; DONE in the cycle after edge T(REG_SIZE+1).
// Backpressure: READY_A/B only while idle; a new word can be taken during the DONE cycle.
module shift_load_controller
   import shift_ctrl_pkg::*;
#(
   parameter int REG_SIZE = 4
) (
   input  logic                CLOCK,
   input  logic                RESET_N,
   input  logic                VALID_A,
   input  logic [REG_SIZE-1:0] DATA_A,
   output logic                READY_A,
   input  logic                VALID_B,
   input  logic [REG_SIZE-1:0] DATA_B,
   output logic                READY_B,
   input  logic [REG_SIZE-1:0] Q,
   output logic                SHIFT_LEFT,
   output logic                DATA_IN,
   output logic                BUSY,
   output logic                DONE,
   output logic                DONE_SRC,
   output logic                ERR
);

   localparam int CW = cnt_width(REG_SIZE);
   localparam logic [CW-1:0] CNT_LAST = CW'(REG_SIZE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t              state;
   state_t              state_nxt;
   logic [REG_SIZE-1:0] word;
   logic [REG_SIZE-1:0] word_nxt;
   logic                src;
   logic                src_nxt;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_nxt;
   logic                shift_nxt;
   logic                din_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic                dsrc_nxt;
   logic                err_nxt;

   logic                arb_en;
   logic                grant_a;
   logic                grant_b;
   logic                accept;
   logic [REG_SIZE-1:0] sel_word;
   logic [REG_SIZE-1:0] word_sh;

   // READY must read 0 during reset, so the arbiter is also gated by RESET_N.
   assign arb_en  = (state == ST_IDLE) & RESET_N;
   assign READY_A = grant_a;
   assign READY_B = grant_b;
   // A grant already implies the matching VALID, so any grant is an accept.
   assign accept  = grant_a | grant_b;

   rr_arbiter_2 u_arb (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .VALID_A (VALID_A),
      .VALID_B (VALID_B),
      .enable  (arb_en),
      .GRANT_A (grant_a),
      .GRANT_B (grant_b)
   );

   // Word presented by the granted requester, and the latched word aligned so the
   // next bit to send (index REG_SIZE-2-cnt) sits in the MSB position.
   always_comb begin
      sel_word = grant_b ? DATA_B : DATA_A;
      word_sh  = word << (cnt + CNT_ONE);
   end

   // FSM state register.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus next values of every registered output and datapath register.
   always_comb begin
      state_nxt = state;
      word_nxt  = word;
      src_nxt   = src;
      cnt_nxt   = cnt;
      shift_nxt = SHIFT_LEFT;
      din_nxt   = DATA_IN;
      busy_nxt  = BUSY;
      done_nxt  = 1'b0;
      dsrc_nxt  = SRC_A;
      err_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            shift_nxt = 1'b0;
            din_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            if (accept) begin
               word_nxt  = sel_word;
               src_nxt   = grant_b ? SRC_B : SRC_A;
               shift_nxt = 1'b1;
               din_nxt   = sel_word[REG_SIZE-1];
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            cnt_nxt = cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
               // Register has now captured all REG_SIZE bits.
               shift_nxt = 1'b0;
               din_nxt   = 1'b0;
               state_nxt = ST_CHECK;
            end else begin
               din_nxt = word_sh[REG_SIZE-1];
            end
         end
         ST_CHECK: begin
            done_nxt  = 1'b1;
            dsrc_nxt  = src;
            err_nxt   = (Q != word);
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end
         default: begin
            shift_nxt = 1'b0;
            din_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath and output registers; reset aborts a load without any DONE.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         word       <= '0;
         src        <= SRC_A;
         cnt        <= '0;
         SHIFT_LEFT <= 1'b0;
         DATA_IN    <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         DONE_SRC   <= SRC_A;
         ERR        <= 1'b0;
      end else begin
         word       <= word_nxt;
         src        <= src_nxt;
         cnt        <= cnt_nxt;
         SHIFT_LEFT <= shift_nxt;
         DATA_IN    <= din_nxt;
         BUSY       <= busy_nxt;
         DONE       <= done_nxt;
         DONE_SRC   <= dsrc_nxt;
         ERR        <= err_nxt;
      end
   end

endmodule

// File: tb/tb_shift_load_controller.sv
// Bench for shift_load_controller with a behavioural shift register and load model.
// Latency: checks every cycle on the falling edge against a transaction-phase model.
// Backpressure: requesters hold VALID until accepted, or drop it at random.
module tb_shift_load_controller;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         va = 1'b0;
   logic         vb = 1'b0;
   logic [N-1:0] da = '0;
   logic [N-1:0] db = '0;
   logic         ready_a;
   logic         ready_b;
   logic [N-1:0] q;
   logic         sl;
   logic         di;
   logic         busy;
   logic         done;
   logic         dsrc;
   logic         err;

   logic [N-1:0] q_reg = '0;
   logic         stuck = 1'b0;
   logic         chk_on = 1'b0;
   int           asserts = 0;
   int           fails = 0;
   int           cyc = 0;

   always #5 clk = ~clk;

   shift_load_controller #(.REG_SIZE(N)) dut (
      .CLOCK      (clk),
      .RESET_N    (rst_n),
      .VALID_A    (va),
      .DATA_A     (da),
      .READY_A    (ready_a),
      .VALID_B    (vb),
      .DATA_B     (db),
      .READY_B    (ready_b),
      .Q          (q),
      .SHIFT_LEFT (sl),
      .DATA_IN    (di),
      .BUSY       (busy),
      .DONE       (done),
      .DONE_SRC   (dsrc),
      .ERR        (err)
   );

   // The controlled left-shift register, optionally replaced by a stuck-at-zero stub.
   always @(posedge clk) if (sl) q_reg <= {q_reg[N-2:0], di};
   assign q = stuck ? '0 : q_reg;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic bit_of(input logic [N-1:0] w, input int i);
      logic [N-1:0] t;
      t = w >> i;
      return t[0];
   endfunction

   // ---------------- behavioural model ----------------
   // A load is a phase count p since its accept edge: p<N shifting, p==N checking,
   // p==N+1 reporting DONE (already idle).
   logic         m_act = 1'b0;
   int           m_p = 0;
   logic [N-1:0] m_word = '0;
   logic         m_src = 1'b0;
   logic         m_prio_b = 1'b0;
   logic         m_err = 1'b0;
   logic         tka;
   logic         tkb;

   logic m_idle, m_ga, m_gb, e_sl, e_di, e_busy, e_done, e_err;
   assign m_idle = !(m_act && m_p <= N);
   assign m_ga   = rst_n && m_idle && va && (!vb || !m_prio_b);
   assign m_gb   = rst_n && m_idle && vb && (!va || m_prio_b);
   assign e_sl   = m_act && (m_p < N);
   assign e_di   = e_sl ? bit_of(m_word, N - 1 - m_p) : 1'b0;
   assign e_busy = m_act && (m_p <= N);
   assign e_done = m_act && (m_p == N + 1);
   assign e_err  = e_done && m_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act = 1'b0; m_p = 0; m_prio_b = 1'b0; m_err = 1'b0; m_src = 1'b0; m_word = '0;
      end else begin
         tka = m_ga;
         tkb = m_gb;
         if (m_act) begin
            if (m_p == N) m_err = ((stuck ? '0 : m_word) != m_word);
            m_p = m_p + 1;
            if (m_p > N + 1) m_act = 1'b0;
         end
         if (tka || tkb) begin
            m_act = 1'b1;
            m_p = 0;
            m_word = tkb ? db : da;
            m_src = tkb;
            m_prio_b = tka;
         end
      end
   end

   // Compare every output against the model on the falling edge.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("ready_a", 32'(ready_a), 32'(m_ga));
         chk("ready_b", 32'(ready_b), 32'(m_gb));
         chk("shift_left", 32'(sl), 32'(e_sl));
         chk("data_in", 32'(di), 32'(e_di));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
         chk("err", 32'(err), 32'(e_err));
         if (e_done) begin
            chk("done_src", 32'(dsrc), 32'(m_src));
            chk("q_at_done", 32'(q), 32'(stuck ? '0 : m_word));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_acc(input bit use_b, output int t);
      bit got = 1'b0;
      t = -1;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (use_b ? (ready_b && vb) : (ready_a && va)) got = 1'b1;
      end
      chk("accept_seen", 32'(got), 32'd1);
      if (got) begin
         @(posedge clk);
         #1;
         t = cyc;
      end
   endtask

   task automatic wait_done(input logic [N-1:0] eq, input bit eerr, input bit esrc);
      bit got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk("done_seen", 32'(got), 32'd1);
      if (got) begin
         chk("lit_q", 32'(q), 32'(eq));
         chk("lit_err", 32'(err), 32'(eerr));
         chk("lit_src", 32'(dsrc), 32'(esrc));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ta, tb2, t1, t2, cnt;
      bit got;
      logic [N-1:0] ev;
      logic [N-1:0] tmp;
      logic acc_a, acc_b;

      // Reset: READY must stay low even with both requesters valid.
      va = 1'b1; vb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_a", 32'(ready_a), 32'd0);
      chk("rst_ready_b", 32'(ready_b), 32'd0);
      chk("rst_shift", 32'(sl), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      va = 1'b0; vb = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // 1: A alone sends 1101; bit stream 1,1,0,1 then DONE at p=N+1.
      @(posedge clk); #1;
      da = 4'b1101; va = 1'b1;
      wait_acc(1'b0, ta);
      va = 1'b0;
      ev = 4'b1101;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         tmp = ev << i;
         chk("t1_shift", 32'(sl), 32'd1);
         chk("t1_bit", 32'(di), 32'(tmp[N-1]));
      end
      @(negedge clk);
      chk("t1_check_shift", 32'(sl), 32'd0);
      chk("t1_check_busy", 32'(busy), 32'd1);
      chk("t1_check_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_q", 32'(q), 32'(4'b1101));
      chk("t1_err", 32'(err), 32'd0);
      chk("t1_src", 32'(dsrc), 32'd0);

      // 2: both valid from reset, A first, B in A's DONE cycle, then A wins again.
      @(posedge clk); #1;
      rst_n = 1'b0; #2; rst_n = 1'b1;
      da = 4'b1000; db = 4'b0110; va = 1'b1; vb = 1'b1;
      @(negedge clk);
      chk("t2_first_a", 32'(ready_a), 32'd1);
      chk("t2_first_b", 32'(ready_b), 32'd0);
      @(posedge clk); #1;
      va = 1'b0;
      ta = cyc;
      wait_acc(1'b1, tb2);
      chk("t2_b_gap", 32'(tb2 - ta), 32'd6);
      va = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (ready_a || ready_b) got = 1'b1;
      end
      chk("t2_rr_a", 32'(ready_a), 32'd1);
      chk("t2_rr_b", 32'(ready_b), 32'd0);
      @(posedge clk); #1;
      va = 1'b0; vb = 1'b0;
      wait_done(4'b1000, 1'b0, 1'b0);

      // 3: B sends 1111 then 0000 back-to-back.
      @(posedge clk); #1;
      db = 4'b1111; vb = 1'b1;
      wait_acc(1'b1, t1);
      db = 4'b0000;
      wait_acc(1'b1, t2);
      vb = 1'b0;
      chk("t3_gap", 32'(t2 - t1), 32'd6);
      wait_done(4'b0000, 1'b0, 1'b1);

      // 4: stuck-at-zero register, A sends 1010 -> ERR.
      @(posedge clk); #1;
      stuck = 1'b1; da = 4'b1010; va = 1'b1;
      wait_acc(1'b0, ta);
      va = 1'b0;
      wait_done(4'b0000, 1'b1, 1'b0);
      @(posedge clk); #1;
      stuck = 1'b0;

      // 5: reset in the 2nd SHIFT cycle of a B load.
      db = 4'b0101; vb = 1'b1;
      wait_acc(1'b1, tb2);
      vb = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t5_shift", 32'(sl), 32'd0);
      chk("t5_din", 32'(di), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("t5_no_done", 32'(cnt), 32'd0);
      @(posedge clk); #1;
      va = 1'b1; vb = 1'b1; da = 4'b0011; db = 4'b1100;
      @(negedge clk);
      chk("t5_after_a", 32'(ready_a), 32'd1);
      chk("t5_after_b", 32'(ready_b), 32'd0);
      @(posedge clk); #1;
      va = 1'b0; vb = 1'b0;
      wait_done(4'b0011, 1'b0, 1'b0);
      // Pointer favours B after an A load; reset must restore A priority.
      @(posedge clk); #1;
      da = 4'b0110; va = 1'b1;
      wait_acc(1'b0, ta);
      va = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0; #2; rst_n = 1'b1;
      va = 1'b1; vb = 1'b1; da = 4'b1001; db = 4'b0111;
      @(negedge clk);
      chk("t5_ptr_a", 32'(ready_a), 32'd1);
      chk("t5_ptr_b", 32'(ready_b), 32'd0);
      @(posedge clk); #1;
      va = 1'b0; vb = 1'b0;
      wait_done(4'b1001, 1'b0, 1'b0);

      // 6: idle for 20 cycles, then DATA toggled while busy.
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sl) cnt++;
      end
      chk("t6_idle_shift", 32'(cnt), 32'd0);
      @(posedge clk); #1;
      da = 4'b0011; va = 1'b1;
      wait_acc(1'b0, ta);
      va = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         da = N'($urandom);
         db = N'($urandom);
      end
      wait_done(4'b0011, 1'b0, 1'b0);

      // Randomised traffic with drops, data churn, stuck periods and stray resets.
      acc_a = 1'b0; acc_b = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         acc_a = ready_a && va;
         acc_b = ready_b && vb;
         @(posedge clk); #1;
         if (acc_a) begin
            va = ($urandom_range(0, 3) == 0); da = N'($urandom);
         end else if (va) begin
            if ($urandom_range(0, 9) == 0) va = 1'b0;
            if ($urandom_range(0, 7) == 0) da = N'($urandom);
         end else if ($urandom_range(0, 2) == 0) begin
            va = 1'b1; da = N'($urandom);
         end
         if (acc_b) begin
            vb = ($urandom_range(0, 3) == 0); db = N'($urandom);
         end else if (vb) begin
            if ($urandom_range(0, 9) == 0) vb = 1'b0;
            if ($urandom_range(0, 7) == 0) db = N'($urandom);
         end else if ($urandom_range(0, 2) == 0) begin
            vb = 1'b1; db = N'($urandom);
         end
         if ($urandom_range(0, 15) == 0) stuck = ~stuck;
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 1'b0; #2; rst_n = 1'b1;
         end
      end
      va = 1'b0; vb = 1'b0; stuck = 1'b0;
      repeat (N + 4) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
